// File: rtl/cycpuf_pkg.sv
// Shared types, constants and helpers for the CycPUF challenge/response driver.
package cycpuf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      RESULT = 2'd3
   } crp_state_e;

   localparam int SYNC_DEPTH = 2;

   // Galois feedback masks for maximal-length LFSRs; bit k set means tap x^(k+1).
   function automatic logic [31:0] lfsr_taps(input int width);
      logic [31:0] taps;
      case (width)
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0829;
         13:      taps = 32'h0000_100D;
         14:      taps = 32'h0000_2015;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_D008;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0004_0023;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

   // A bit votes 1 when its ones-count strictly exceeds this value.
   function automatic int maj_threshold(input int num_samples);
      return num_samples / 2;
   endfunction

endpackage

// File: rtl/cycpuf_vote_acc.sv
// Per-bit ones-counters with clear/enable; vote and unstable outputs already
// include the sample presented this cycle so the final edge can register them.
module cycpuf_vote_acc
   import cycpuf_pkg::*;
#(
   parameter int W = 15,
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] sample,
   output logic [W-1:0] vote,
   output logic [W-1:0] unstable
);
   localparam int            CW  = $clog2(N + 1);
   localparam logic [CW-1:0] THR = CW'(maj_threshold(N));
   localparam logic [CW-1:0] ALL = CW'(N);

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         logic [CW-1:0] ones_q, ones_d, ones_incl;

         assign ones_incl = ones_q + CW'(sample[gi]);

         always_comb begin
            ones_d = ones_q;
            if (clr) begin
               ones_d = '0;
            end else if (en) begin
               ones_d = ones_incl;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ones_q <= '0;
            end else begin
               ones_q <= ones_d;
            end
         end

         assign vote[gi]     = ones_incl > THR;
         assign unstable[gi] = (ones_incl != '0) && (ones_incl != ALL);
      end
   endgenerate

endmodule

// File: rtl/cycpuf_crp_driver.sv
// CycPUF initiator: applies a challenge, waits to settle, majority-votes repeated
// response samples. Define CYCPUF_LFSR_CHAL_EN to add LFSR self-launched challenges.
module cycpuf_crp_driver
   import cycpuf_pkg::*;
#(
   parameter int CHAL_W      = 15,
   parameter int SETTLE_CYC  = 8,
   parameter int NUM_SAMPLES = 5,
   parameter int LFSR_SEED   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef CYCPUF_LFSR_CHAL_EN
   input  logic              auto_en,
`endif
   input  logic              chal_valid,
   output logic              chal_ready,
   input  logic [CHAL_W-1:0] chal_data,
   output logic [CHAL_W-1:0] puf_chal,
   input  logic [CHAL_W-1:0] puf_resp,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [CHAL_W-1:0] rsp_data,
   output logic [CHAL_W-1:0] rsp_unstable,
   output logic [CHAL_W-1:0] rsp_chal,
   output logic              busy
);
   localparam int               CNT_MAX     = (SETTLE_CYC > NUM_SAMPLES) ? SETTLE_CYC : NUM_SAMPLES;
   localparam int               CNT_W       = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);

   crp_state_e                       state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [CHAL_W-1:0]                puf_chal_q, puf_chal_d;
   logic [CHAL_W-1:0]                rsp_chal_q, rsp_chal_d;
   logic [CHAL_W-1:0]                rsp_data_q, rsp_data_d;
   logic [CHAL_W-1:0]                rsp_unst_q, rsp_unst_d;
   logic                             rsp_valid_q, rsp_valid_d;
   logic [SYNC_DEPTH-1:0][CHAL_W-1:0] sync_q;
   logic                             acc_clr, acc_en;
   logic [CHAL_W-1:0]                vote, unstable;
   logic                             launch;
   logic [CHAL_W-1:0]                launch_chal;

`ifdef CYCPUF_LFSR_CHAL_EN
   localparam logic [CHAL_W-1:0] TAPS = CHAL_W'(lfsr_taps(CHAL_W));
   logic [CHAL_W-1:0] lfsr_q, lfsr_d;
   logic              auto_go;

   // External challenges win; the LFSR only advances when it is actually used.
   assign auto_go     = (state_q == IDLE) && auto_en && !chal_valid;
   assign launch      = (state_q == IDLE) && (chal_valid || auto_en);
   assign launch_chal = chal_valid ? chal_data : lfsr_q;
   assign lfsr_d      = auto_go ? ({1'b0, lfsr_q[CHAL_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0)) : lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= CHAL_W'(LFSR_SEED);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   logic unused_seed;
   assign unused_seed = ^LFSR_SEED;
   assign launch      = (state_q == IDLE) && chal_valid;
   assign launch_chal = chal_data;
`endif

   // puf_resp comes from an unclocked array, so it is resynchronized before use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= puf_resp;
         for (int i = 1; i < SYNC_DEPTH; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   cycpuf_vote_acc #(
      .W (CHAL_W),
      .N (NUM_SAMPLES)
   ) u_vote_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .en       (acc_en),
      .sample   (sync_q[SYNC_DEPTH-1]),
      .vote     (vote),
      .unstable (unstable)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      puf_chal_d  = puf_chal_q;
      rsp_chal_d  = rsp_chal_q;
      rsp_data_d  = rsp_data_q;
      rsp_unst_d  = rsp_unst_q;
      rsp_valid_d = rsp_valid_q;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               puf_chal_d = launch_chal;
               rsp_chal_d = launch_chal;
               cnt_d      = '0;
               acc_clr    = 1'b1;
               state_d    = APPLY;
            end
         end
         APPLY: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SAMPLE: begin
            acc_en = 1'b1;
            if (cnt_q == SAMPLE_LAST) begin
               rsp_data_d  = vote;
               rsp_unst_d  = unstable;
               rsp_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = RESULT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESULT: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         puf_chal_q  <= '0;
         rsp_chal_q  <= '0;
         rsp_data_q  <= '0;
         rsp_unst_q  <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         puf_chal_q  <= puf_chal_d;
         rsp_chal_q  <= rsp_chal_d;
         rsp_data_q  <= rsp_data_d;
         rsp_unst_q  <= rsp_unst_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign chal_ready   = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign puf_chal     = puf_chal_q;
   assign rsp_chal     = rsp_chal_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_unstable = rsp_unst_q;
   assign rsp_valid    = rsp_valid_q;

endmodule

// File: tb/tb_cycpuf_crp_driver.sv
// Bench for cycpuf_crp_driver: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cycpuf_crp_driver;
   localparam int W = 15;
   localparam int S = 4;
   localparam int N = 5;
   localparam int HIST = 1024;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         chal_valid = 1'b0;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] chal_data = '0;
   logic [W-1:0] puf_resp = '0;
   logic         chal_ready, rsp_valid, busy;
   logic [W-1:0] puf_chal, rsp_data, rsp_unstable, rsp_chal;
`ifdef CYCPUF_LFSR_CHAL_EN
   logic         auto_en = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   cycpuf_crp_driver #(
      .CHAL_W      (W),
      .SETTLE_CYC  (S),
      .NUM_SAMPLES (N),
      .LFSR_SEED   (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef CYCPUF_LFSR_CHAL_EN
      .auto_en      (auto_en),
`endif
      .chal_valid   (chal_valid),
      .chal_ready   (chal_ready),
      .chal_data    (chal_data),
      .puf_chal     (puf_chal),
      .puf_resp     (puf_resp),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_unstable (rsp_unstable),
      .rsp_chal     (rsp_chal),
      .busy         (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // The response seen at the k-th sample is the raw value present two edges earlier,
   // so a challenge accepted at edge A votes over raw inputs of edges A+S-1 .. A+S+N-2.
   int           cyc = 0;
   int           m_phase = 0;  // 0 idle, 1 working, 2 result pending
   int           m_acc = 0;
   logic         m_valid = 1'b0;
   logic [W-1:0] m_pchal = '0, m_chal = '0, m_data = '0, m_unst = '0;
   logic [W-1:0] resp_at [0:HIST-1];
`ifdef CYCPUF_LFSR_CHAL_EN
   logic [W-1:0] m_lfsr = 15'h0001;
`endif

   function automatic logic [2*W-1:0] vote_of(input int first);
      logic [W-1:0] d, u;
      int ones;
      d = '0;
      u = '0;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         for (int k = 0; k < N; k++) ones += int'(resp_at[(first + k) % HIST][b]);
         d[b] = (2 * ones > N);
         u[b] = (ones != 0) && (ones != N);
      end
      return {u, d};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_valid <= 1'b0;
         m_pchal <= '0;
         m_chal  <= '0;
         m_data  <= '0;
         m_unst  <= '0;
`ifdef CYCPUF_LFSR_CHAL_EN
         m_lfsr  <= 15'h0001;
`endif
      end else begin
         resp_at[cyc % HIST] <= puf_resp;
         cyc <= cyc + 1;
         case (m_phase)
            0: begin
               if (chal_valid) begin
                  m_phase <= 1; m_acc <= cyc; m_pchal <= chal_data; m_chal <= chal_data;
               end
`ifdef CYCPUF_LFSR_CHAL_EN
               else if (auto_en) begin
                  m_phase <= 1; m_acc <= cyc; m_pchal <= m_lfsr; m_chal <= m_lfsr;
                  m_lfsr  <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 15'h6000) : (m_lfsr >> 1);
               end
`endif
            end
            1: begin
               if (cyc == m_acc + S + N) begin
                  {m_unst, m_data} <= vote_of(m_acc + S - 1);
                  m_valid <= 1'b1;
                  m_phase <= 2;
               end
            end
            default: begin
               if (rsp_ready) begin
                  m_valid <= 1'b0;
                  m_phase <= 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("chal_ready", {31'b0, chal_ready}, {31'b0, m_phase == 0});
         check("busy",       {31'b0, busy},       {31'b0, m_phase != 0});
         check("rsp_valid",  {31'b0, rsp_valid},  {31'b0, m_valid});
         check("puf_chal",   {17'b0, puf_chal},   {17'b0, m_pchal});
         check("rsp_chal",   {17'b0, rsp_chal},   {17'b0, m_chal});
         check("rsp_data",   {17'b0, rsp_data},   {17'b0, m_data});
         check("rsp_unst",   {17'b0, rsp_unstable}, {17'b0, m_unst});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic accept(input logic [W-1:0] c);
      chal_data  = c;
      chal_valid = 1'b1;
      step();
      chal_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      while (!rsp_valid && lat < budget) begin
         step();
         lat++;
      end
      if (!rsp_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid timeout @%0t: rsp_valid stayed 0 for %0d cycles", $time, budget);
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic run_pattern(input logic [W-1:0] c, input logic [4:0] p);
      accept(c);
      for (int k = 1; k <= 9; k++) begin
         puf_resp = (k >= 3 && k <= 7) ? {14'b0, p[k-3]} : '0;
         step();
      end
      check("t3 valid", {31'b0, rsp_valid}, 32'h1);
   endtask

   initial begin
      int lat;
      repeat (3) step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      step();

      // Stable response and latency
      puf_resp = 15'h1234;
      accept(15'h1A2B);
      check("t2 puf_chal", {17'b0, puf_chal}, 32'h1A2B);
      wait_valid(20, lat);
      check("t2 latency", lat, 9);
      check("t2 rsp_data", {17'b0, rsp_data}, 32'h1234);
      check("t2 rsp_unst", {17'b0, rsp_unstable}, 32'h0);
      check("t2 rsp_chal", {17'b0, rsp_chal}, 32'h1A2B);
      handshake();

      // Noisy bit 0
      run_pattern(15'h0003, 5'b10101);
      check("t3a rsp_data", {17'b0, rsp_data}, 32'h0001);
      check("t3a rsp_unst", {17'b0, rsp_unstable}, 32'h0001);
      handshake();
      run_pattern(15'h0004, 5'b10000);
      check("t3b rsp_data", {17'b0, rsp_data}, 32'h0000);
      check("t3b rsp_unst", {17'b0, rsp_unstable}, 32'h0001);
      handshake();

      // Backpressure with a competing challenge
      puf_resp = 15'h0AAA;
      accept(15'h0555);
      wait_valid(20, lat);
      chal_data  = 15'h2222;
      chal_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t4 held valid", {31'b0, rsp_valid}, 32'h1);
         check("t4 no ready", {31'b0, chal_ready}, 32'h0);
         check("t4 held chal", {17'b0, rsp_chal}, 32'h0555);
      end
      check("t4 rsp_data", {17'b0, rsp_data}, 32'h0AAA);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("t4 idle ready", {31'b0, chal_ready}, 32'h1);
      step();
      chal_valid = 1'b0;
      check("t4 reaccept", {31'b0, busy}, 32'h1);
      check("t4 new chal", {17'b0, puf_chal}, 32'h2222);
      wait_valid(20, lat);
      handshake();

      // Asynchronous reset mid-cycle while a result is pending
      puf_resp = 15'h3C3C;
      accept(15'h1111);
      wait_valid(20, lat);
      puf_resp = W'($urandom);
      rst_n = 1'b0;
      #1;
      check("t1 rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check("t1 rsp_data", {17'b0, rsp_data}, 32'h0);
      check("t1 rsp_chal", {17'b0, rsp_chal}, 32'h0);
      check("t1 puf_chal", {17'b0, puf_chal}, 32'h0);
      check("t1 chal_ready", {31'b0, chal_ready}, 32'h1);
      check("t1 busy", {31'b0, busy}, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Reset during SAMPLE must leave no stale counts
      puf_resp = 15'h5555;
      accept(15'h3333);
      repeat (6) step();
      rst_n = 1'b0;
      puf_resp = 15'h7FFF;
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      accept(15'h0F0F);
      wait_valid(20, lat);
      check("t5 rsp_data", {17'b0, rsp_data}, 32'h7FFF);
      check("t5 rsp_unst", {17'b0, rsp_unstable}, 32'h0);
      check("t5 rsp_chal", {17'b0, rsp_chal}, 32'h0F0F);
      handshake();

`ifdef CYCPUF_LFSR_CHAL_EN
      begin
         logic [W-1:0] exp_seq [0:3];
         exp_seq[0] = 15'h0001;
         exp_seq[1] = 15'h6000;
         exp_seq[2] = 15'h3000;
         exp_seq[3] = 15'h1800;
         rsp_ready = 1'b1;
         auto_en   = 1'b1;
         for (int i = 0; i < 4; i++) begin
            wait_valid(20, lat);
            check("t6 lfsr chal", {17'b0, rsp_chal}, {17'b0, exp_seq[i]});
            check("t6 nonzero", {31'b0, rsp_chal != '0}, 32'h1);
            if (i == 3) begin
               chal_data  = 15'h0ABC;
               chal_valid = 1'b1;
            end
            step();
         end
         step();
         chal_valid = 1'b0;
         wait_valid(20, lat);
         check("t6 override", {17'b0, rsp_chal}, 32'h0ABC);
         step();
         wait_valid(20, lat);
         check("t6 resume", {17'b0, rsp_chal}, 32'h0C00);
         auto_en = 1'b0;
         step();
         rsp_ready = 1'b0;
      end
`endif

      repeat (3) step();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
